// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU-control issue stage: ALUOp classes, 5-bit ALU op codes,
// memory access sizes and funct7 patterns.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        ALUOP_MEM = 2'b00,
        ALUOP_LUI = 2'b01,
        ALUOP_R   = 2'b10,
        ALUOP_I   = 2'b11
    } aluop_e;

    typedef enum logic [4:0] {
        ALU_AND     = 5'b00000,
        ALU_OR      = 5'b00001,
        ALU_ADD     = 5'b00010,
        ALU_XOR     = 5'b00011,
        ALU_SLL     = 5'b00100,
        ALU_SRL     = 5'b00101,
        ALU_SUB     = 5'b00110,
        ALU_SRA     = 5'b00111,
        ALU_SLT     = 5'b01000,
        ALU_SLTU    = 5'b01001,
        ALU_PASSB   = 5'b01110,
        ALU_MUL     = 5'b10000,
        ALU_MULH    = 5'b10001,
        ALU_MULHSU  = 5'b10010,
        ALU_MULHU   = 5'b10011,
        ALU_DIV     = 5'b10100,
        ALU_DIVU    = 5'b10101,
        ALU_REM     = 5'b10110,
        ALU_REMU    = 5'b10111,
        ALU_INVALID = 5'b11111
    } alu_op_e;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/alu_ctrl_lane_decode.sv
// Combinational single-lane decoder from {ALUOp, funct3, funct7} to ALU op, mem size and flags.
// M-extension decode is enabled by defining ALU_CTRL_MULDIV_EN.
module alu_ctrl_lane_decode
    import alu_ctrl_pkg::*;
(
    input  logic       lane_valid,
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [4:0] alu_ctrl,
    output logic [1:0] mem_size,
    output logic       mem_unsigned,
    output logic       illegal
);

    alu_op_e op;
    logic    ill;
    logic [1:0] size;
    logic    uns;

    always_comb begin
        op   = ALU_INVALID;
        ill  = 1'b0;
        size = MEM_BYTE;
        uns  = 1'b0;
        case (aluop_e'(aluop))
            ALUOP_MEM: begin
                op   = ALU_ADD;
                size = funct3[1:0];
                uns  = funct3[2];
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
                    ill = 1'b1;
                end
            end
            ALUOP_LUI: op = ALU_PASSB;
            ALUOP_R: begin
                case (funct7)
                    F7_BASE: begin
                        case (funct3)
                            3'b000:  op = ALU_ADD;
                            3'b001:  op = ALU_SLL;
                            3'b010:  op = ALU_SLT;
                            3'b011:  op = ALU_SLTU;
                            3'b100:  op = ALU_XOR;
                            3'b101:  op = ALU_SRL;
                            3'b110:  op = ALU_OR;
                            default: op = ALU_AND;
                        endcase
                    end
                    F7_ALT: begin
                        if (funct3 == 3'b000) begin
                            op = ALU_SUB;
                        end else if (funct3 == 3'b101) begin
                            op = ALU_SRA;
                        end else begin
                            ill = 1'b1;
                        end
                    end
                    F7_MULDIV: begin
`ifdef ALU_CTRL_MULDIV_EN
                        op = alu_op_e'({2'b10, funct3});
`else
                        ill = 1'b1;
`endif
                    end
                    default: ill = 1'b1;
                endcase
            end
            default: begin
                // Immediate forms only look at funct7 for the shift encodings.
                case (funct3)
                    3'b000: op = ALU_ADD;
                    3'b010: op = ALU_SLT;
                    3'b011: op = ALU_SLTU;
                    3'b100: op = ALU_XOR;
                    3'b110: op = ALU_OR;
                    3'b111: op = ALU_AND;
                    3'b001: begin
                        if (funct7 == F7_BASE) op = ALU_SLL;
                        else ill = 1'b1;
                    end
                    default: begin
                        if (funct7 == F7_BASE) op = ALU_SRL;
                        else if (funct7 == F7_ALT) op = ALU_SRA;
                        else ill = 1'b1;
                    end
                endcase
            end
        endcase

        if (ill || !lane_valid) begin
            op   = ALU_INVALID;
            size = MEM_BYTE;
            uns  = 1'b0;
        end
        if (!lane_valid) begin
            ill = 1'b0;
        end
    end

    assign alu_ctrl     = op;
    assign mem_size     = size;
    assign mem_unsigned = uns;
    assign illegal      = ill;

endmodule

// File: rtl/alu_ctrl_issue_stage.sv
// Registered multi-lane ALU-control issue stage: per-lane decode, 2-entry skid buffer,
// flush and saturating illegal-op counter. Optional M-ext decode via ALU_CTRL_MULDIV_EN.
module alu_ctrl_issue_stage
    import alu_ctrl_pkg::*;
#(
    parameter int LANES = 2,
    parameter int TAG_W = 6,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES-1:0]     in_lane_valid,
    input  logic [2*LANES-1:0]   in_aluop,
    input  logic [3*LANES-1:0]   in_funct3,
    input  logic [7*LANES-1:0]   in_funct7,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES-1:0]     out_lane_valid,
    output logic [5*LANES-1:0]   out_alu_ctrl,
    output logic [2*LANES-1:0]   out_mem_size,
    output logic [LANES-1:0]     out_mem_unsigned,
    output logic [LANES-1:0]     out_illegal,
    output logic [TAG_W-1:0]     out_tag,
    output logic [CNT_W-1:0]     illegal_count
);

    // Entry layout, LSB first: lane_valid, alu_ctrl, mem_size, unsigned, illegal, tag.
    localparam int ENTRY_W = 10 * LANES + TAG_W;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W+2:0] CNT_MAX_EXT = {3'b000, CNT_MAX};

    logic [5*LANES-1:0] dec_ctrl;
    logic [2*LANES-1:0] dec_size;
    logic [LANES-1:0]   dec_uns;
    logic [LANES-1:0]   dec_ill;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        alu_ctrl_lane_decode u_dec (
            .lane_valid   (in_lane_valid[i]),
            .aluop        (in_aluop[2*i +: 2]),
            .funct3       (in_funct3[3*i +: 3]),
            .funct7       (in_funct7[7*i +: 7]),
            .alu_ctrl     (dec_ctrl[5*i +: 5]),
            .mem_size     (dec_size[2*i +: 2]),
            .mem_unsigned (dec_uns[i]),
            .illegal      (dec_ill[i])
        );
    end

    logic               e0_full_q, e0_full_d;
    logic               e1_full_q, e1_full_d;
    logic [ENTRY_W-1:0] e0_data_q, e0_data_d;
    logic [ENTRY_W-1:0] e1_data_q, e1_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ENTRY_W-1:0] new_entry;
    logic               accept;
    logic               transfer;
    logic [3:0]         ill_pad;
    logic [CNT_W+2:0]   cnt_sum;

    assign new_entry = {in_tag, dec_ill, dec_uns, dec_size, dec_ctrl, in_lane_valid};
    assign accept    = in_valid & ~e1_full_q & ~flush;
    assign transfer  = e0_full_q & out_ready;

    // Entry1 is only ever occupied while entry0 is, so entry0 always holds the oldest bundle.
    always_comb begin
        e0_full_d = e0_full_q;
        e1_full_d = e1_full_q;
        e0_data_d = e0_data_q;
        e1_data_d = e1_data_q;
        cnt_d     = cnt_q;
        ill_pad   = '0;
        ill_pad[LANES-1:0] = dec_ill;
        cnt_sum   = {3'b000, cnt_q} + {{CNT_W{1'b0}}, popcount4(ill_pad)};

        if (flush) begin
            e0_full_d = 1'b0;
            e1_full_d = 1'b0;
            e0_data_d = '0;
            e1_data_d = '0;
        end else if (!e0_full_q) begin
            if (accept) begin
                e0_full_d = 1'b1;
                e0_data_d = new_entry;
            end
        end else if (!e1_full_q) begin
            if (transfer && accept) begin
                e0_data_d = new_entry;
            end else if (transfer) begin
                e0_full_d = 1'b0;
                e0_data_d = '0;
            end else if (accept) begin
                e1_full_d = 1'b1;
                e1_data_d = new_entry;
            end
        end else if (transfer) begin
            e0_data_d = e1_data_q;
            e1_full_d = 1'b0;
            e1_data_d = '0;
        end

        if (accept) begin
            cnt_d = (cnt_sum > CNT_MAX_EXT) ? CNT_MAX : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e0_full_q <= 1'b0;
            e1_full_q <= 1'b0;
            e0_data_q <= '0;
            e1_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            e0_full_q <= e0_full_d;
            e1_full_q <= e1_full_d;
            e0_data_q <= e0_data_d;
            e1_data_q <= e1_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign in_ready         = ~e1_full_q;
    assign out_valid        = e0_full_q;
    assign out_lane_valid   = e0_data_q[0 +: LANES];
    assign out_alu_ctrl     = e0_data_q[LANES +: 5*LANES];
    assign out_mem_size     = e0_data_q[6*LANES +: 2*LANES];
    assign out_mem_unsigned = e0_data_q[8*LANES +: LANES];
    assign out_illegal      = e0_data_q[9*LANES +: LANES];
    assign out_tag          = e0_data_q[10*LANES +: TAG_W];
    assign illegal_count    = cnt_q;

endmodule
